// File: rtl/fdivsqrt_pkg.sv
// Shared types and widths for the divide/sqrt result-side logic.
package fdivsqrt_pkg;

    localparam int DIVB_DEF = 59;
    localparam int RESW_DEF = DIVB_DEF + 4;
    localparam int QW_DEF   = DIVB_DEF + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESOLVE = 2'd2,
        HOLD    = 2'd3
    } resq_state_t;

endpackage

// File: rtl/fdivsqrt_resq_if.sv
// Handshake and datapath bundle between the iteration core, the result
// stage and the FPU writeback stage.
interface fdivsqrt_resq_if
    import fdivsqrt_pkg::*;
#(
    parameter int DIVb = DIVB_DEF
);
    logic              StartE;
    logic              SqrtE;
    logic              FlushE;
    logic [DIVb+3:0]   FirstWS;
    logic [DIVb+3:0]   FirstWC;
    logic [DIVb:0]     FirstU;
    logic [DIVb:0]     FirstUM;
    logic              BusyE;
    logic              ResValid;
    logic              ResReady;
    logic [DIVb:0]     QM;
    logic              StickyM;
    logic              SqrtM;

    modport slave (
        input  StartE, SqrtE, FlushE, FirstWS, FirstWC, FirstU, FirstUM, ResReady,
        output BusyE, ResValid, QM, StickyM, SqrtM
    );

    modport master (
        output StartE, SqrtE, FlushE, FirstWS, FirstWC, FirstU, FirstUM, ResReady,
        input  BusyE, ResValid, QM, StickyM, SqrtM
    );
endinterface

// File: rtl/fdivsqrt_ressign.sv
// Carry-save residual resolve: WS+WC with wrap, then sign and zero detect.
module fdivsqrt_ressign
    import fdivsqrt_pkg::*;
#(
    parameter int W = RESW_DEF
) (
    input  logic [W-1:0] i_ws,
    input  logic [W-1:0] i_wc,
    output logic         o_neg,
    output logic         o_zero
);
    logic [W-1:0] w_sum;

    assign w_sum  = i_ws + i_wc;
    assign o_neg  = w_sum[W-1];
    assign o_zero = (w_sum == '0);
endmodule

// File: rtl/fdivsqrt_resq.sv
// Result-side sequencer for the divide/sqrt iteration core.
// Optional early termination on an exact remainder: FDIVSQRT_EARLYTERM_EN.
//
//   state   | meaning
//   IDLE    | waiting for StartE
//   BUSY    | core iterating; snapshot captured on the last iteration
//   RESOLVE | residual sign/zero resolved, QM and StickyM registered
//   HOLD    | result presented until ResReady
module fdivsqrt_resq
    import fdivsqrt_pkg::*;
#(
    parameter int DIVb   = DIVB_DEF,
    parameter int CYCLES = 15,
    parameter int CNTW   = $clog2(CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    fdivsqrt_resq_if.slave  bus
);
    localparam int RESW = DIVb + 4;
    localparam int QW   = DIVb + 1;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_BUSY    = BUSY;
    localparam logic [1:0] ST_RESOLVE = RESOLVE;
    localparam logic [1:0] ST_HOLD    = HOLD;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CYCLES - 1);

    logic [1:0]      r_state;
    logic [CNTW-1:0] r_cnt;
    logic [RESW-1:0] r_ws, r_wc;
    logic [QW-1:0]   r_u, r_um;
    logic [QW-1:0]   r_qm;
    logic            r_sticky;
    logic            r_sqrt;
    logic            r_early;

    logic            w_neg, w_zero;
    logic            w_early;
    logic            w_capture;

    fdivsqrt_ressign #(.W(RESW)) u_resolve (
        .i_ws   (r_ws),
        .i_wc   (r_wc),
        .o_neg  (w_neg),
        .o_zero (w_zero)
    );

`ifdef FDIVSQRT_EARLYTERM_EN
    logic w_et_neg, w_et_zero;

    fdivsqrt_ressign #(.W(RESW)) u_earlyterm (
        .i_ws   (bus.FirstWS),
        .i_wc   (bus.FirstWC),
        .o_neg  (w_et_neg),
        .o_zero (w_et_zero)
    );

    // Exact remainder seen before the last iteration: finish now.
    assign w_early = (r_state == ST_BUSY) && w_et_zero && (r_cnt != '0);
`else
    assign w_early = 1'b0;
`endif

    assign w_capture = (r_state == ST_BUSY) && ((r_cnt == '0) || w_early);

    // Snapshot of the core's start-of-cycle residual and result words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ws <= '0;
            r_wc <= '0;
            r_u  <= '0;
            r_um <= '0;
        end else if (w_capture) begin
            r_ws <= bus.FirstWS;
            r_wc <= bus.FirstWC;
            r_u  <= bus.FirstU;
            r_um <= bus.FirstUM;
        end
    end

    // Sequencer, iteration counter and held result; flush overrides all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_qm     <= '0;
            r_sticky <= 1'b0;
            r_sqrt   <= 1'b0;
            r_early  <= 1'b0;
        end else if (bus.FlushE) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_qm     <= '0;
            r_sticky <= 1'b0;
            r_early  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.StartE) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= CNT_LOAD;
                        r_sqrt  <= bus.SqrtE;
                    end
                end
                ST_BUSY: begin
                    if (w_capture) begin
                        r_state <= ST_RESOLVE;
                        r_cnt   <= '0;
                        r_early <= w_early;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                ST_RESOLVE: begin
                    r_state  <= ST_HOLD;
                    r_qm     <= w_neg ? r_um : r_u;
                    r_sticky <= ~w_zero & ~r_early;
                end
                ST_HOLD: begin
                    if (bus.ResReady) begin
                        if (bus.StartE) begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CNT_LOAD;
                            r_sqrt  <= bus.SqrtE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.BusyE    = (r_state == ST_BUSY);
    assign bus.ResValid = (r_state == ST_HOLD);
    assign bus.QM       = r_qm;
    assign bus.StickyM  = r_sticky;
    assign bus.SqrtM    = r_sqrt;

endmodule
